fp_acc_seq: RTL and testbench
=============================

Name: fp_acc_seq

Overview:
- Serial fp16 reduction sequencer for the division PE.
- Accepts a stream of `len` half-precision operands and drives operands into an external combinational FP_ADD instance (a, b, rnd).
- Consumes that instance's z/status outputs and returns the final sum plus accumulated exception flags through a valid/ready result port.
- Sits directly around the PE adder: upstream as operand feeder, downstream as result consumer.

Parameters:
- SIG_WIDTH, 10, fraction bits; matches adder sig_width.
- EXP_WIDTH, 5, exponent bits; matches adder exp_width.
- CNT_WIDTH, 8, width of the element-count field.
- RND_MODE, 3'b000, rounding mode driven on add_rnd (000 = round-to-nearest-even).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a reduction; sampled only in IDLE.
- len  in  CNT_WIDTH  element count; sampled with start.
- in_valid  in  1  operand valid.
- in_data  in  SIG_WIDTH+EXP_WIDTH+1  fp16 operand.
- in_ready  out  1  operand accept.
- add_a  out  SIG_WIDTH+EXP_WIDTH+1  adder operand a; always equals the acc register.
- add_b  out  SIG_WIDTH+EXP_WIDTH+1  adder operand b; always equals the op register.
- add_rnd  out  3  constant RND_MODE.
- add_z  in  SIG_WIDTH+EXP_WIDTH+1  adder sum, combinational from add_a/add_b.
- add_status  in  8  adder status (bit0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact).
- out_valid  out  1  result valid.
- out_data  out  SIG_WIDTH+EXP_WIDTH+1  final sum.
- out_status  out  8  result flags.
- out_ready  in  1  result accept.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async):
  - state = IDLE; acc, op_reg, remaining, sticky flags all 0; op_vld = 0.
  - Outputs: in_ready = 0, out_valid = 0, out_data = 0, out_status = 0, busy = 0.
  - A reset asserted mid-reduction aborts it with no output; no state survives.
- State machine: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start with len != 0: acc <= 16'h0000 (+0), sticky <= 0, remaining <= len, go to ACCUM.
  - start with len == 0: acc <= 0, sticky <= 0, go directly to DONE.
- ACCUM:
  - in_ready = 1.
  - Accept (in_valid & in_ready): op_reg <= in_data, op_vld <= 1, remaining <= remaining - 1. No accept: op_vld <= 0.
  - Accepting with remaining == 1 moves to DRAIN.
  - Throughput is 1 element per cycle; gaps in in_valid are allowed.
- Any cycle with op_vld = 1, in any state: acc <= add_z and sticky[7:1] |= add_status[7:1].
  - Accepting a new operand in the same cycle is legal: the adder consumes the old op_reg.
  - When op_vld = 0, add_z/add_status are ignored.
- DRAIN:
  - in_ready = 0; the final op_reg is summed; op_vld <= 0; go to DONE.
- DONE:
  - out_valid = 1, out_data = acc.
  - out_status[7:1] = sticky[7:1]; out_status[0] = 1 iff acc[14:0] == 0, i.e. the final zero flag, which is not sticky.
  - Outputs hold stable while out_ready = 0. out_valid & out_ready returns to IDLE.
- Latency: last element accepted in cycle t gives out_valid high in cycle t+2. len == 0 gives out_valid high 1 cycle after start.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored (not accepted).
- Flags: NaN/Inf propagation and rounding are entirely the adder's behaviour. Once acc is Inf, it stays Inf unless an opposite-sign Inf yields NaN; the block passes whatever add_z returns.
- Counter: remaining never wraps; len == 2^CNT_WIDTH-1 is the maximum.

Test Plan:
- Basic sum: start, len=3, in_data 3C00 (1.0), 4000 (2.0), 3800 (0.5) back-to-back, out_ready=1 -> out_data 4300 (3.5), out_status 00, out_valid exactly 2 cycles after the 3rd accept.
- Empty reduction: start with len=0 -> out_valid next cycle, out_data 0000, out_status 01.
- Cancellation: len=2, 3C00 then BC00 -> out_data 0000, out_status[0]=1.
- Overflow: len=2, 7BFF then 7BFF -> out_data 7C00, out_status bits 1, 4, 5 set (0x32).
- Stall/bubbles:
  - len=4 with in_valid low on alternate cycles, 3C00 each -> 4400.
  - Hold out_ready=0 for 5 cycles -> out_data/out_status stable, in_ready=0, a start pulse is ignored.
- Reset mid-run: assert rst after 2 of 4 elements -> all outputs 0 immediately, IDLE. Then a new len=1 run with 4200 -> out_data 4200.

Source files
------------

// File: rtl/fp_acc_seq.sv
`default_nettype none
// ============================================================================
// fp_acc_seq : serial fp16 reduction sequencer around an external FP adder
// Revision   : 1.0
// ============================================================================
module fp_acc_seq #(
    parameter int         SIG_WIDTH = 10,
    parameter int         EXP_WIDTH = 5,
    parameter int         CNT_WIDTH = 8,
    parameter logic [2:0] RND_MODE  = 3'b000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           len,
    input  logic                           in_valid,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_data,
    output logic                           in_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   add_a,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   add_b,
    output logic [2:0]                     add_rnd,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   add_z,
    input  logic [7:0]                     add_status,
    output logic                           out_valid,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   out_data,
    output logic [7:0]                     out_status,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [W-1:0]         acc;
    logic [W-1:0]         op_reg;
    logic [CNT_WIDTH-1:0] remaining;
    logic [7:0]           sticky;
    logic                 op_vld;
    logic                 accept;
    logic                 acc_zero;

    assign accept   = in_valid & in_ready;
    assign acc_zero = ~|acc[W-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            op_reg    <= '0;
            remaining <= '0;
            sticky    <= '0;
            op_vld    <= 1'b0;
        end else begin
            op_vld <= 1'b0;
            // The adder always sees the previous operand, so a fresh accept
            // can overlap with folding the old one into acc.
            if (op_vld) begin
                acc    <= add_z;
                sticky <= sticky | (add_status & 8'hFE);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        sticky    <= '0;
                        remaining <= len;
                        state     <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        op_reg    <= in_data;
                        op_vld    <= 1'b1;
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_data   = out_valid ? acc : '0;
    // Zero flag reflects only the final value; the rest are sticky.
    assign out_status = out_valid ? ((sticky & 8'hFE) | {7'b0, acc_zero}) : 8'h00;
    assign add_a      = acc;
    assign add_b      = op_reg;
    assign add_rnd    = RND_MODE;

endmodule
`default_nettype wire

// File: tb/tb_fp_acc_seq.sv
`default_nettype none
// ============================================================================
// tb_fp_acc_seq : directed bench with a table-driven fp16 adder stand-in
// Revision      : 1.0
// ============================================================================
module tb_fp_acc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [2:0]  add_rnd;
    logic [15:0] add_z;
    logic [7:0]  add_status;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_status;
    logic        out_ready;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    int cyc;

    always #5 clk = ~clk;

    fp_acc_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_rnd    (add_rnd),
        .add_z      (add_z),
        .add_status (add_status),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_status (out_status),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // Exact fp16 sums for the operand pairs the vectors produce; anything
    // else returns a NaN with invalid set so a wrong pairing shows up.
    always_comb begin
        add_z      = 16'h7E00;
        add_status = 8'h04;
        if (add_a == 16'h0000) begin
            add_z      = add_b;
            add_status = (add_b[14:0] == 15'h0) ? 8'h01 : 8'h00;
        end else begin
            case ({add_a, add_b})
                {16'h3C00, 16'h4000}: begin add_z = 16'h4200; add_status = 8'h00; end
                {16'h4200, 16'h3800}: begin add_z = 16'h4300; add_status = 8'h00; end
                {16'h3C00, 16'hBC00}: begin add_z = 16'h0000; add_status = 8'h01; end
                {16'h7BFF, 16'h7BFF}: begin add_z = 16'h7C00; add_status = 8'h32; end
                {16'h3C00, 16'h3C00}: begin add_z = 16'h4000; add_status = 8'h00; end
                {16'h4000, 16'h3C00}: begin add_z = 16'h4200; add_status = 8'h00; end
                {16'h4200, 16'h3C00}: begin add_z = 16'h4400; add_status = 8'h00; end
                default: begin add_z = 16'h7E00; add_status = 8'h04; end
            endcase
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d, input int gap);
        for (int i = 0; i < gap; i++) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns cycles elapsed until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        #12;
        check_val("rst_in_ready",  in_ready,   0);
        check_val("rst_out_valid", out_valid,  0);
        check_val("rst_out_data",  out_data,   0);
        check_val("rst_out_status", out_status, 0);
        check_val("rst_busy",      busy,       0);
        check_val("add_rnd",       add_rnd,    0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // basic sum 1.0 + 2.0 + 0.5
        start_run(8'd3);
        check_val("basic_in_ready", in_ready, 1);
        feed(16'h3C00, 0);
        feed(16'h4000, 0);
        feed(16'h3800, 0);
        check_val("basic_drain_no_valid", out_valid, 0);
        wait_done(cyc);
        check_val("basic_latency", cyc, 1);
        check_val("basic_data",   out_data,   16'h4300);
        check_val("basic_status", out_status, 8'h00);
        consume();
        check_val("basic_idle", busy, 0);

        // empty reduction
        start_run(8'd0);
        check_val("empty_valid",  out_valid,  1);
        check_val("empty_data",   out_data,   16'h0000);
        check_val("empty_status", out_status, 8'h01);
        consume();

        // cancellation
        start_run(8'd2);
        feed(16'h3C00, 0);
        feed(16'hBC00, 0);
        wait_done(cyc);
        check_val("cancel_data",   out_data,   16'h0000);
        check_val("cancel_status", out_status, 8'h01);
        consume();

        // overflow to +Inf
        start_run(8'd2);
        feed(16'h7BFF, 0);
        feed(16'h7BFF, 0);
        wait_done(cyc);
        check_val("ovf_data",   out_data,   16'h7C00);
        check_val("ovf_status", out_status, 8'h32);
        consume();

        // bubbles between operands, then back-pressure on the result
        start_run(8'd4);
        feed(16'h3C00, 1);
        feed(16'h3C00, 1);
        feed(16'h3C00, 1);
        feed(16'h3C00, 1);
        wait_done(cyc);
        check_val("bubble_latency", cyc, 1);
        check_val("bubble_data", out_data, 16'h4400);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd1;
            in_valid = 1'b1;
            in_data  = 16'h3800;
            tick();
            check_val("hold_valid",    out_valid,  1);
            check_val("hold_data",     out_data,   16'h4400);
            check_val("hold_status",   out_status, 8'h00);
            check_val("hold_in_ready", in_ready,   0);
        end
        start = 1'b0;
        in_valid = 1'b0;
        consume();
        check_val("hold_start_ignored", busy, 0);

        // reset mid-run
        start_run(8'd4);
        feed(16'h3C00, 0);
        feed(16'h3C00, 0);
        tick();
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy",     busy,       0);
        check_val("mid_rst_in_ready", in_ready,   0);
        check_val("mid_rst_valid",    out_valid,  0);
        check_val("mid_rst_data",     out_data,   0);
        check_val("mid_rst_status",   out_status, 0);
        check_val("mid_rst_add_a",    add_a,      0);
        check_val("mid_rst_add_b",    add_b,      0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        start_run(8'd1);
        feed(16'h4200, 0);
        wait_done(cyc);
        check_val("post_rst_latency", cyc, 1);
        check_val("post_rst_data",   out_data,   16'h4200);
        check_val("post_rst_status", out_status, 8'h00);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
